// File: rtl/lif_array.sv
// lif_array: N-channel leaky-integrate-and-fire neuron array.
// Each step strobe applies a shift leak to every channel and adds that channel's
// input current with saturation. A channel at or above THRESHOLD fires instead
// and then resets to zero or drops by THRESHOLD.
// The optional per-channel refractory counter is enabled by defining LIF_ARRAY_REFRAC_EN.
module lif_array #(
    parameter int unsigned N             = 4,
    parameter int unsigned W             = 8,
    parameter int unsigned THRESHOLD     = 200,
    parameter int unsigned LEAK_SHIFT    = 1,
    parameter int unsigned RESET_MODE    = 0,
    parameter int unsigned REFRAC_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           step,
    input  logic [N*W-1:0] current,
    output logic [N*W-1:0] state,
    output logic [N-1:0]   spike,
    output logic           spike_any
);

    localparam logic [W-1:0] THR = W'(THRESHOLD);

    logic [N-1:0] fire_vec_c;
    logic         spike_any_q;

`ifdef LIF_ARRAY_REFRAC_EN
    localparam logic [3:0] REFRAC_LOAD = 4'(REFRAC_CYCLES);
`else
    logic unused_refrac_cfg;
    assign unused_refrac_cfg = ^(4'(REFRAC_CYCLES));
`endif

    for (genvar g = 0; g < N; g++) begin : g_ch
        logic [W-1:0] state_q, state_d;
        logic         spike_q;
        logic [W-1:0] s, c, c_eff, leaked;
        logic [W:0]   sum;
        logic         quiet;
        logic         fire;

        assign s = state_q;
        assign c = current[g*W +: W];

`ifdef LIF_ARRAY_REFRAC_EN
        logic [3:0] refrac_q, refrac_d;

        assign quiet = (refrac_q != 4'd0);

        // Refractory counter: load on a firing step, count down on quiet steps
        always_comb begin
            refrac_d = refrac_q;
            if (step) begin
                if (fire) begin
                    refrac_d = REFRAC_LOAD;
                end else if (quiet) begin
                    refrac_d = refrac_q - 4'd1;
                end
            end
        end

        // Refractory counter register
        always_ff @(posedge clk) begin
            if (rst) begin
                refrac_q <= 4'd0;
            end else begin
                refrac_q <= refrac_d;
            end
        end
`else
        assign quiet = 1'b0;
`endif

        // A quiet (refractory) channel still leaks but ignores its input and cannot fire
        assign c_eff  = quiet ? {W{1'b0}} : c;
        assign leaked = s - (s >> LEAK_SHIFT);
        assign sum    = {1'b0, leaked} + {1'b0, c_eff};
        assign fire   = !quiet && (s >= THR);

        assign fire_vec_c[g] = step & fire;

        // Next membrane value: hold, fire/reset, or leak+integrate with clamp
        always_comb begin
            state_d = state_q;
            if (step) begin
                if (fire) begin
                    state_d = (RESET_MODE == 0) ? {W{1'b0}} : (s - THR);
                end else begin
                    state_d = sum[W] ? {W{1'b1}} : sum[W-1:0];
                end
            end
        end

        // Membrane and spike registers
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= {W{1'b0}};
                spike_q <= 1'b0;
            end else begin
                state_q <= state_d;
                spike_q <= fire_vec_c[g];
            end
        end

        assign state[g*W +: W] = state_q;
        assign spike[g]        = spike_q;
    end

    // Registered OR of all channel spikes
    always_ff @(posedge clk) begin
        if (rst) begin
            spike_any_q <= 1'b0;
        end else begin
            spike_any_q <= |fire_vec_c;
        end
    end

    assign spike_any = spike_any_q;

endmodule

// File: tb/tb_lif_array.sv
// Directed self-checking bench for lif_array (default build and refractory build).
module tb_lif_array;

    logic        clk;
    logic        rst, step;
    logic [31:0] current;
    logic [31:0] state;
    logic [3:0]  spike;
    logic        spike_any;

    logic        rst1, step1;
    logic [31:0] current1;
    logic [31:0] state1;
    logic [3:0]  spike1;
    logic        spike_any1;

    int total = 0;
    int bad   = 0;

    lif_array dut (
        .clk(clk), .rst(rst), .step(step), .current(current),
        .state(state), .spike(spike), .spike_any(spike_any)
    );

    lif_array #(.RESET_MODE(1)) dut_sub (
        .clk(clk), .rst(rst1), .step(step1), .current(current1),
        .state(state1), .spike(spike1), .spike_any(spike_any1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic r, input logic s, input logic [31:0] cur);
        rst = r; step = s; current = cur;
        @(posedge clk); #1;
    endtask

    task automatic cyc1(input logic r, input logic s, input logic [31:0] cur);
        rst1 = r; step1 = s; current1 = cur;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        cyc(1'b1, 1'b1, 32'hFFFF_FFFF);
        total++; if (state !== 32'h0) begin bad++; $display("FAIL reset_state: got %h expected %h", state, 32'h0); end
        total++; if (spike !== 4'h0) begin bad++; $display("FAIL reset_spike: got %b expected %b", spike, 4'h0); end
        total++; if (spike_any !== 1'b0) begin bad++; $display("FAIL reset_spike_any: got %b expected 0", spike_any); end
        // all channels saturate-free load to 255, then all fire together
        cyc(1'b0, 1'b1, 32'hFFFF_FFFF);
        total++; if (state !== 32'hFFFF_FFFF) begin bad++; $display("FAIL load_all: got %h expected %h", state, 32'hFFFF_FFFF); end
        cyc(1'b0, 1'b1, 32'h0);
        total++; if (spike !== 4'hF || spike_any !== 1'b1 || state !== 32'h0) begin
            bad++; $display("FAIL fire_all: got spike=%b any=%b state=%h expected spike=1111 any=1 state=0", spike, spike_any, state);
        end
        // reset mid-operation beats step and leaves no spike
        cyc(1'b0, 1'b1, 32'hFFFF_FFFF);
        cyc(1'b1, 1'b1, 32'hFFFF_FFFF);
        total++; if (state !== 32'h0 || spike !== 4'h0 || spike_any !== 1'b0) begin
            bad++; $display("FAIL reset_priority: got state=%h spike=%b any=%b expected 0", state, spike, spike_any);
        end
    endtask

    task automatic test_integrate;
        logic [7:0] exp_seq [8];
        exp_seq = '{8'd100, 8'd150, 8'd175, 8'd188, 8'd194, 8'd197, 8'd199, 8'd200};
        cyc(1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b1, 32'd100);
            total++; if (state[7:0] !== exp_seq[k] || spike !== 4'h0) begin
                bad++; $display("FAIL integrate_step%0d: got state0=%0d spike=%b expected %0d 0000", k, state[7:0], spike, exp_seq[k]);
            end
            total++; if (state[31:8] !== 24'h0) begin
                bad++; $display("FAIL idle_channels%0d: got %h expected 0", k, state[31:8]);
            end
        end
        cyc(1'b0, 1'b1, 32'd100);
        total++; if (spike !== 4'b0001 || spike_any !== 1'b1 || state[7:0] !== 8'd0) begin
            bad++; $display("FAIL fire_ch0: got spike=%b any=%b state0=%0d expected 0001 1 0", spike, spike_any, state[7:0]);
        end
        cyc(1'b0, 1'b0, 32'd100);
        total++; if (spike !== 4'h0 || spike_any !== 1'b0 || state[7:0] !== 8'd0) begin
            bad++; $display("FAIL spike_pulse: got spike=%b any=%b state0=%0d expected 0000 0 0", spike, spike_any, state[7:0]);
        end
    endtask

    task automatic test_saturation;
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 32'd100 << 8);
        total++; if (state[15:8] !== 8'd100) begin bad++; $display("FAIL sat_1: got %0d expected 100", state[15:8]); end
        cyc(1'b0, 1'b1, 32'd100 << 8);
        total++; if (state[15:8] !== 8'd150) begin bad++; $display("FAIL sat_2: got %0d expected 150", state[15:8]); end
        cyc(1'b0, 1'b1, 32'd200 << 8);
        total++; if (state[15:8] !== 8'd255 || spike !== 4'h0) begin
            bad++; $display("FAIL sat_clamp: got state1=%0d spike=%b expected 255 0000", state[15:8], spike);
        end
        cyc(1'b0, 1'b1, 32'h0);
        total++; if (spike !== 4'b0010 || spike_any !== 1'b1 || state[15:8] !== 8'd0) begin
            bad++; $display("FAIL sat_fire: got spike=%b any=%b state1=%0d expected 0010 1 0", spike, spike_any, state[15:8]);
        end
    endtask

    task automatic test_hold;
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 32'd100);
        cyc(1'b0, 1'b1, 32'd100);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b0, 32'hFFFF_FFFF);
            total++; if (state !== 32'd150 || spike !== 4'h0 || spike_any !== 1'b0) begin
                bad++; $display("FAIL hold%0d: got state=%h spike=%b any=%b expected %h 0000 0", k, state, spike, spike_any, 32'd150);
            end
        end
    endtask

    task automatic test_subtract;
        cyc1(1'b1, 1'b0, 32'h0);
        cyc1(1'b0, 1'b1, 32'd255 << 16);
        total++; if (state1[23:16] !== 8'd255 || spike1 !== 4'h0) begin
            bad++; $display("FAIL sub_load: got state2=%0d spike=%b expected 255 0000", state1[23:16], spike1);
        end
        cyc1(1'b0, 1'b1, 32'd255 << 16);
        total++; if (spike1 !== 4'b0100 || spike_any1 !== 1'b1 || state1[23:16] !== 8'd55) begin
            bad++; $display("FAIL sub_fire: got spike=%b any=%b state2=%0d expected 0100 1 55", spike1, spike_any1, state1[23:16]);
        end
        // 55 - 27 + 255 = 283 -> clamps
        cyc1(1'b0, 1'b1, 32'd255 << 16);
        total++; if (state1[23:16] !== 8'd255 || spike1 !== 4'h0) begin
            bad++; $display("FAIL sub_after: got state2=%0d spike=%b expected 255 0000", state1[23:16], spike1);
        end
    endtask

    task automatic test_refrac;
        logic [7:0] exp_st [5];
        logic [3:0] exp_sp [5];
`ifdef LIF_ARRAY_REFRAC_EN
        exp_st = '{8'd255, 8'd0, 8'd0, 8'd0, 8'd255};
        exp_sp = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
`else
        exp_st = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd255};
        exp_sp = '{4'h0, 4'h1, 4'h0, 4'h1, 4'h0};
`endif
        cyc(1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b1, 32'd255);
            total++; if (state[7:0] !== exp_st[k] || spike !== exp_sp[k]) begin
                bad++; $display("FAIL refrac_step%0d: got state0=%0d spike=%b expected %0d %b", k, state[7:0], spike, exp_st[k], exp_sp[k]);
            end
        end
        // reset in the middle of the refractory window
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 32'd255);
        cyc(1'b0, 1'b1, 32'd255);
        cyc(1'b1, 1'b1, 32'd255);
        total++; if (state !== 32'h0 || spike !== 4'h0) begin
            bad++; $display("FAIL refrac_rst: got state=%h spike=%b expected 0 0000", state, spike);
        end
        cyc(1'b0, 1'b1, 32'd255);
        total++; if (state[7:0] !== 8'd255 || spike !== 4'h0) begin
            bad++; $display("FAIL refrac_after_rst: got state0=%0d spike=%b expected 255 0000", state[7:0], spike);
        end
    endtask

    initial begin
        rst = 1'b1; step = 1'b0; current = '0;
        rst1 = 1'b1; step1 = 1'b0; current1 = '0;
        test_reset();
        test_integrate();
        test_saturation();
        test_hold();
        test_subtract();
        test_refrac();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
